exp_result_fifo: RTL and testbench

- Downstream buffer for the parameterised power pipeline: captures its o_valid/o_data result stream (one result per cycle, no stall capability) into a first-word-fall-through FIFO.
- Presents results to a consumer over a valid/ready handshake.
- Decouples the free-running pipeline from a consumer that may back-pressure.
- Flags any result lost to overflow.

---
 rtl/exp_result_fifo.sv | 113 +++++++++++
 tb/tb_exp_result_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/exp_result_fifo.sv
// First-word-fall-through result buffer between the free-running power pipeline and a back-pressuring consumer.
// Optional running sum of popped words is enabled by defining EXP_RESULT_FIFO_SUM_EN.
module exp_result_fifo #(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_almost_full,
    output logic                       o_overflow
`ifdef EXP_RESULT_FIFO_SUM_EN
    ,
    output logic [DATA_W-1:0]          o_sum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_nxt;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              empty, full, push, pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FULL_C);
        pop      = !empty && i_ready;
        push     = i_valid && (!full || pop);
        rd_nxt   = rd_ptr_q + PTR_W'(1);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_nxt : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + ONE_C;
        end else if (pop && !push) begin
            count_d = count_q - ONE_C;
        end

        // Head register: the incoming word becomes head when the FIFO is
        // (or is about to be) empty; otherwise the next stored entry moves up.
        data_d = data_q;
        if (push && (empty || (pop && count_q == ONE_C))) begin
            data_d = i_data;
        end else if (pop && count_q > ONE_C) begin
            data_d = mem_q[rd_nxt];
        end

        ovf_d = ovf_q || (i_valid && !push);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef EXP_RESULT_FIFO_SUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = pop ? sum_q + data_q : sum_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign o_sum = sum_q;
`endif

    assign o_valid       = !empty;
    assign o_data        = data_q;
    assign o_count       = count_q;
    assign o_almost_full = (count_q >= AFULL_C);
    assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_exp_result_fifo.sv
// Bench for exp_result_fifo: queue-based reference model checked every cycle, plus literal checks
// from the power-pipeline scenarios. Define EXP_RESULT_FIFO_SUM_EN to also check o_sum.
module tb_exp_result_fifo;

    localparam int DATA_W    = 64;
    localparam int DEPTH     = 8;
    localparam int AFULL_LVL = 6;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_count;
    logic              o_almost_full;
    logic              o_overflow;
`ifdef EXP_RESULT_FIFO_SUM_EN
    logic [DATA_W-1:0] o_sum;
`endif

    always #5 clk = ~clk;

    exp_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .clk(clk),
        .rst(rst),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_valid(o_valid),
        .o_data(o_data),
        .i_ready(i_ready),
        .o_count(o_count),
        .o_almost_full(o_almost_full),
        .o_overflow(o_overflow)
`ifdef EXP_RESULT_FIFO_SUM_EN
        ,
        .o_sum(o_sum)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: queue contents, last shown head word, sticky drop flag, running sum.
    logic [63:0] mq[$];
    logic [63:0] m_last = '0;
    logic [63:0] m_sum  = '0;
    bit          m_ovf  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pw8(input int b);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < 8; k++) r = r * 64'(b);
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("cyc_valid", 64'(o_valid), 64'(mq.size() != 0));
            chk("cyc_count", 64'(o_count), 64'(mq.size()));
            chk("cyc_data", o_data, m_last);
            chk("cyc_afull", 64'(o_almost_full), 64'(mq.size() >= AFULL_LVL));
            chk("cyc_ovf", 64'(o_overflow), 64'(m_ovf));
`ifdef EXP_RESULT_FIFO_SUM_EN
            chk("cyc_sum", o_sum, m_sum);
`endif
        end
    end

    // One clock cycle of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input bit v, input logic [63:0] d, input bit r);
        bit pop, push;
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        pop  = (mq.size() != 0) && r;
        push = v && ((mq.size() < DEPTH) || pop);
        @(posedge clk);
        #1;
        if (pop) m_sum = m_sum + mq.pop_front();
        if (push) mq.push_back(d);
        if (v && !push) m_ovf = 1'b1;
        if (mq.size() != 0) m_last = mq[0];
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        i_valid = 1'b0;
        i_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_afull", 64'(o_almost_full), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
`ifdef EXP_RESULT_FIFO_SUM_EN
        chk("rst_sum", o_sum, 64'd0);
`endif
        @(negedge clk);
        #2;
        rst = 1'b0;
        mq.delete();
        m_last = '0;
        m_sum  = '0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        bit v, r;
        int rbias;
        logic [63:0] d;

        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", 64'(o_valid), 64'd0);
        chk("init_count", 64'(o_count), 64'd0);
        chk("init_data", o_data, 64'd0);
        chk("init_ovf", 64'(o_overflow), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // Back-to-back fill with consumer stalled.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pw8(i), 1'b0);
            chk("fill_count", 64'(o_count), 64'(i + 1));
            chk("fill_afull", 64'(o_almost_full), 64'(i >= 5));
            chk("fill_data", o_data, 64'd0);
            chk("fill_ovf", 64'(o_overflow), 64'd0);
        end

        // Overflow: 8^8 is dropped, flag sticks.
        step(1'b1, 64'd16777216, 1'b0);
        chk("ovf_set", 64'(o_overflow), 64'd1);
        chk("ovf_count", 64'(o_count), 64'd8);
        step(1'b0, 64'd0, 1'b0);
        chk("ovf_sticky", 64'(o_overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", o_data, pw8(i));
            step(1'b0, 64'd0, 1'b1);
        end
        chk("drain_empty", 64'(o_valid), 64'd0);
        chk("drain_last", o_data, 64'd5764801);
        chk("drain_ovf", 64'(o_overflow), 64'd1);
`ifdef EXP_RESULT_FIFO_SUM_EN
        chk("sum_lit", o_sum, 64'd7907396);
        step(1'b0, 64'd0, 1'b1);
        chk("sum_hold", o_sum, 64'd7907396);
`endif

        // Pass-through at full rate.
        async_reset();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, pw8(i), 1'b1);
            chk("pt_data", o_data, pw8(i));
            chk("pt_count", 64'(o_count), 64'd1);
        end
        chk("pt_last", o_data, 64'd9227446944279201);
        chk("pt_ovf", 64'(o_overflow), 64'd0);
        step(1'b0, 64'd0, 1'b1);
        chk("pt_empty", 64'(o_valid), 64'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) step(1'b1, {$urandom(), $urandom()}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, {$urandom(), $urandom()}, 1'b1);
            chk("fp_count", 64'(o_count), 64'd8);
            chk("fp_ovf", 64'(o_overflow), 64'd0);
        end
        repeat (10) step(1'b0, 64'd0, 1'b1);

        // Randomised traffic with varying consumer bias.
        for (int seg = 0; seg < 6; seg++) begin
            rbias = seg % 3;
            for (int n = 0; n < 400; n++) begin
                v = ($urandom_range(0, 3) != 0);
                r = (rbias == 0) ? ($urandom_range(0, 3) == 0) :
                    (rbias == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) != 0);
                d = {$urandom(), $urandom()};
                step(v, d, r);
            end
        end

        // Reset mid-operation with 5 words stored.
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, pw8(i + 10), 1'b0);
        chk("mid_count", 64'(o_count), 64'd5);
        async_reset();
        step(1'b0, 64'd0, 1'b1);
        chk("mid_idle", 64'(o_valid), 64'd0);
        step(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0);
        chk("mid_first", o_data, 64'hDEAD_BEEF_0123_4567);
        chk("mid_cnt1", 64'(o_count), 64'd1);
        step(1'b0, 64'd0, 1'b1);
        chk("mid_drained", 64'(o_valid), 64'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
